// File: rtl/sdram_wb_bridge.sv
// Single-clock bridge from the processor SDRAM bus to the sdram_top req/ack controller.
// Latches one bus transaction, holds the request until acknowledged or timed out, then acks the bus.
module sdram_wb_bridge #(
  parameter int AW      = 21,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [1:0]    wb_sel,
  input  logic [AW-1:0] wb_adr,
  input  logic [15:0]   wb_dat_i,
  output logic [15:0]   wb_dat_o,
  output logic          wb_ack,
  input  logic          mem_ready,
  output logic          mem_wr_req,
  output logic          mem_rd_req,
  input  logic          mem_wr_ack,
  input  logic          mem_rd_ack,
  input  logic [15:0]   mem_rdata,
  output logic [AW:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [1:0]    mem_be,
  output logic          dqm_h,
  output logic          dqm_l,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_t     state_reg;
  logic       we_reg;
  logic       done_reg;
  logic [9:0] cnt_reg;
  logic       match_ack;

  // The bus ack must drop in the same cycle the master releases its strobe.
  assign wb_ack    = wb_stb & done_reg;
  assign match_ack = we_reg ? mem_wr_ack : mem_rd_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      we_reg      <= 1'b0;
      done_reg    <= 1'b0;
      cnt_reg     <= '0;
      wb_dat_o    <= '0;
      mem_wr_req  <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      dqm_h       <= 1'b0;
      dqm_l       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wb_stb && mem_ready) begin
            we_reg     <= wb_we;
            mem_addr   <= {1'b0, wb_adr};
            mem_wdata  <= wb_dat_i;
            mem_wr_req <= wb_we;
            mem_rd_req <= ~wb_we;
            // Reads always fetch the whole word; only writes are byte-masked.
            mem_be     <= wb_we ? wb_sel : 2'b11;
            dqm_h      <= wb_we & ~wb_sel[1];
            dqm_l      <= wb_we & ~wb_sel[0];
            cnt_reg    <= '0;
            state_reg  <= REQ;
          end
        end
        REQ: begin
          if (match_ack) begin
            if (!we_reg) wb_dat_o <= mem_rdata;
            mem_wr_req <= 1'b0;
            mem_rd_req <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            if (!we_reg) wb_dat_o <= 16'hFFFF;
            mem_wr_req  <= 1'b0;
            mem_rd_req  <= 1'b0;
            timeout_err <= 1'b1;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
          end
        end
        DONE: begin
          if (!wb_stb) begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Self-checking bench for sdram_wb_bridge: vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_sdram_wb_bridge;

  localparam int AW = 21;
  localparam int TO = 1023;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_stb, wb_we;
  logic [1:0]    wb_sel;
  logic [AW-1:0] wb_adr;
  logic [15:0]   wb_dat_i, wb_dat_o;
  logic          wb_ack;
  logic          mem_ready;
  logic          mem_wr_req, mem_rd_req, mem_wr_ack, mem_rd_ack;
  logic [15:0]   mem_rdata;
  logic [AW:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic          dqm_h, dqm_l, timeout_err;

  sdram_wb_bridge #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .mem_ready(mem_ready),
    .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req),
    .mem_wr_ack(mem_wr_ack), .mem_rd_ack(mem_rd_ack),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .dqm_h(dqm_h), .dqm_l(dqm_l), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] dat_model;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] dat;
    int          lat;
    logic [15:0] rdata;
    logic        both;
    logic [21:0] e_addr;
    logic [1:0]  e_be;
    logic [1:0]  e_dqm;
    logic [15:0] e_dato;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_wr_req, mem_rd_req, wb_ack, wb_dat_o, mem_addr, mem_wdata,
                mem_be, dqm_h, dqm_l, timeout_err});
  endfunction

  // One complete bus transaction with an idle controller response after `lat` wait cycles.
  task automatic run_txn(input logic we, input logic [1:0] sel, input logic [20:0] adr,
                         input logic [15:0] dat, input int lat, input logic [15:0] rdata,
                         input logic both, input logic [21:0] e_addr, input logic [1:0] e_be,
                         input logic [1:0] e_dqm, input logic [15:0] e_dato);
    wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
    step();
    check("wr_req", 64'(mem_wr_req), 64'(we));
    check("rd_req", 64'(mem_rd_req), 64'(!we));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_be", 64'(mem_be), 64'(e_be));
    check("dqm", 64'({dqm_h, dqm_l}), 64'(e_dqm));
    if (we) check("mem_wdata", 64'(mem_wdata), 64'(dat));
    for (int i = 0; i < lat; i++) begin
      // Noise on the opposite ack must be ignored.
      mem_wr_ack = !we & 1'($urandom_range(0, 1));
      mem_rd_ack = we & 1'($urandom_range(0, 1));
      mem_rdata  = 16'($urandom);
      step();
    end
    check("ack_early", 64'(wb_ack), 64'(0));
    check("req_held", 64'(we ? mem_wr_req : mem_rd_req), 64'(1));
    mem_wr_ack = we | both;
    mem_rd_ack = !we | both;
    mem_rdata  = rdata;
    step();
    mem_wr_ack = 1'b0; mem_rd_ack = 1'b0;
    check("wb_ack", 64'(wb_ack), 64'(1));
    check("req_drop", 64'({mem_wr_req, mem_rd_req}), 64'(0));
    check("wb_dat_o", 64'(wb_dat_o), 64'(e_dato));
    wb_stb = 1'b0;
    #1;
    check("ack_fall", 64'(wb_ack), 64'(0));
    step();
    $display("[TB] txn we=%0d adr=%h sel=%b lat=%0d dat_o=%h", we, adr, sel, lat, wb_dat_o);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b01, 21'h000100, 16'hA55A, 5, 16'h0000, 1'b0, 22'h000100, 2'b01, 2'b10, 16'h0000};
    vecs[1] = '{1'b0, 2'b00, 21'h1FFFFF, 16'h0000, 3, 16'h1234, 1'b0, 22'h1FFFFF, 2'b11, 2'b00, 16'h1234};
    vecs[2] = '{1'b1, 2'b11, 21'h000000, 16'hBEEF, 0, 16'h9999, 1'b1, 22'h000000, 2'b11, 2'b00, 16'h1234};
    vecs[3] = '{1'b1, 2'b10, 21'h0AAAAA, 16'h00C3, 1, 16'h0000, 1'b0, 22'h0AAAAA, 2'b10, 2'b01, 16'h1234};
    vecs[4] = '{1'b0, 2'b01, 21'h155555, 16'h0000, 0, 16'h0000, 1'b1, 22'h155555, 2'b11, 2'b00, 16'h0000};
    vecs[5] = '{1'b1, 2'b00, 21'h000007, 16'h7E7E, 2, 16'h0000, 1'b0, 22'h000007, 2'b00, 2'b11, 16'h0000};

    rst_n = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 2'b00; wb_adr = '0; wb_dat_i = '0;
    mem_ready = 1'b1; mem_wr_ack = 1'b0; mem_rd_ack = 1'b0; mem_rdata = '0;
    dat_model = 16'h0000;
    #12;
    check("reset_outs", all_outs(), 64'(0));
    rst_n = 1'b1;
    step();

    // Directed vectors
    foreach (vecs[i])
      run_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].lat, vecs[i].rdata,
              vecs[i].both, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_dqm, vecs[i].e_dato);
    dat_model = 16'h0000;

    // Strobe while the controller is not ready
    mem_ready = 1'b0;
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h000055;
    for (int i = 0; i < 20; i++) begin
      step();
      check("no_req_unready", 64'({mem_wr_req, mem_rd_req}), 64'(0));
    end
    mem_ready = 1'b1;
    step();
    check("req_on_ready", 64'(mem_rd_req), 64'(1));
    mem_ready = 1'b0;
    step(); step();
    check("ready_drop_ignored", 64'(mem_rd_req), 64'(1));
    mem_rd_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_rd_ack = 1'b0;
    check("ready_ack", 64'(wb_ack), 64'(1));
    check("ready_dat", 64'(wb_dat_o), 64'(16'h5A5A));
    wb_stb = 1'b0; mem_ready = 1'b1;
    step();
    $display("[TB] seq mem_ready gating done");

    // Strobe dropped during a read request
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 21'h000003;
    step();
    check("drop_req", 64'(mem_rd_req), 64'(1));
    wb_stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_req_held", 64'({mem_rd_req, wb_ack}), 64'(2'b10));
    end
    mem_rd_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_rd_ack = 1'b0;
    check("drop_no_ack", 64'({mem_rd_req, wb_ack}), 64'(0));
    step();
    check("drop_idle_no_ack", 64'(wb_ack), 64'(0));
    dat_model = 16'h7777;
    $display("[TB] seq strobe-drop done");
    run_txn(1'b1, 2'b11, 21'h000004, 16'h4444, 2, 16'h0000, 1'b0, 22'h000004, 2'b11, 2'b00, dat_model);

    // Read that the controller never acknowledges
    begin
      int n;
      wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 21'h000077;
      step();
      n = 0;
      while (mem_rd_req && n < 2000) begin
        step();
        n++;
      end
      check("timeout_cycles", 64'(n), 64'(TO + 1));
      check("timeout_err", 64'(timeout_err), 64'(1));
      check("timeout_ack", 64'(wb_ack), 64'(1));
      check("timeout_dat", 64'(wb_dat_o), 64'(16'hFFFF));
      step();
      check("timeout_pulse_once", 64'(timeout_err), 64'(0));
      check("timeout_ack_held", 64'(wb_ack), 64'(1));
      wb_stb = 1'b0;
      step();
      dat_model = 16'hFFFF;
      $display("[TB] seq timeout after %0d cycles", n);
    end

    // Reset in the middle of a write request
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b11; wb_adr = 21'h000042; wb_dat_i = 16'h1111;
    step();
    check("rst_pre_req", 64'(mem_wr_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'(0));
    wb_stb = 1'b0;
    step(); step();
    #2 rst_n = 1'b1;
    step();
    mem_wr_ack = 1'b1;
    step();
    mem_wr_ack = 1'b0;
    check("rst_spurious_ack", 64'({mem_wr_req, mem_rd_req, wb_ack}), 64'(0));
    step();
    dat_model = 16'h0000;
    $display("[TB] seq reset mid-request done");
    run_txn(1'b1, 2'b01, 21'h000042, 16'h2222, 1, 16'h0000, 1'b0, 22'h000042, 2'b01, 2'b10, dat_model);

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      logic        we;
      logic [1:0]  sel;
      logic [20:0] adr;
      logic [15:0] dat, rdata;
      int          lat;
      logic        both;
      we    = 1'($urandom_range(0, 1));
      sel   = 2'($urandom_range(0, 3));
      adr   = 21'($urandom);
      dat   = 16'($urandom);
      rdata = 16'($urandom);
      lat   = int'($urandom_range(0, 6));
      both  = 1'($urandom_range(0, 1));
      if (!we) dat_model = rdata;
      run_txn(we, sel, adr, dat, lat, rdata, both,
              {1'b0, adr}, we ? sel : 2'b11, we ? ~sel : 2'b00, dat_model);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
